next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Parametrised program-counter generator for the multi-cycle/pipelined CPU: it holds the PC register and computes the next fetch address. Sources are sequential (PC+4), PC-relative branch, pseudo-direct jump (region bits of PC+4 concatenated with the 26-bit instruction index, word-aligned) and jump-register. It supports stall, captures redirects that arrive during a stall, and optionally models a single architectural delay slot. It sits between the control unit and instruction memory, replacing the standalone jump-address joiner and PC adder.

## Interface
- ADDR_W, 32: PC width; legal range 28..64.
- RESET_VEC, 32'h0000_0000: PC value after reset; must be word-aligned.
- DELAY_SLOT, 0: 1 = one delay-slot instruction executes before a redirect takes effect.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the PC this cycle
- redirect_valid  in  1  a control transfer is requested this cycle
- redirect_mode  in  2  0 = BRANCH, 1 = JUMP, 2 = JREG, 3 = reserved
- redirect_base  in  ADDR_W  PC of the control instruction
- instr  in  32  control instruction word: [15:0] branch offset, [25:0] jump index
- rs_value  in  ADDR_W  register operand for JREG
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus4  out  ADDR_W  pc + 4 (combinational)
- redirect_pending  out  1  a captured target waits to be applied (registered)
- misaligned  out  1  one-cycle pulse: JREG target had bits [1:0] != 0 (registered)
- redirect_drop  out  1  one-cycle pulse: redirect ignored because one was pending (registered)

## Operation
- Target computation, all modulo 2^ADDR_W, with b4 = redirect_base + 4:
  - BRANCH: b4 + (sign_extend(instr[15:0]) << 2).
  - JUMP: {b4[ADDR_W-1:28], instr[25:0], 2'b00}.
  - JREG: {rs_value[ADDR_W-1:2], 2'b00}. If rs_value[1:0] != 0, pulse misaligned.
  - Reserved mode: the redirect is treated as absent. No capture and no flags.
- The FSM has two states: RUN and HOLD. HOLD means a target register is valid, and redirect_pending = (state == HOLD).
- RUN, redirect accepted (redirect_valid, legal mode):
  - DELAY_SLOT = 0: if not stalled, pc <= target and stay in RUN. If stalled, capture the target and go to HOLD with pc unchanged.
  - DELAY_SLOT = 1: capture the target and go to HOLD. If not stalled, pc <= pc + 4 (delay slot). If stalled, pc is held.
- RUN, no redirect: pc <= pc + 4 unless stalled.
- HOLD, not stalled:
  - DELAY_SLOT = 0: pc <= target, then go to RUN.
  - DELAY_SLOT = 1: if the delay slot was already fetched, pc <= target and go to RUN. Otherwise pc <= pc + 4 and stay in HOLD. A 1-bit slot_done flag tracks this.
- HOLD, stalled: everything is held.
- Any redirect_valid seen in HOLD is dropped and pulses redirect_drop. The pending target always wins.
- Wrap-around: pc + 4 from the top word wraps to 0 with no flag.

## Timing
- Reset values: pc = RESET_VEC, state = RUN, slot_done = 0, target = 0, and misaligned, redirect_drop and redirect_pending = 0.
- Asynchronous assertion of rst_n takes effect immediately, even mid-HOLD, and discards any pending target.
- The first post-reset increment happens on the first rising edge with rst_n high and stall low.
- Redirect latency with DELAY_SLOT = 0, unstalled: 1 cycle (pc shows the target after the next edge).
- Redirect latency with DELAY_SLOT = 1, unstalled: 2 cycles (slot address, then the target).
- Each stalled cycle adds exactly one cycle of latency.
- misaligned and redirect_drop assert on the edge after the offending input and last exactly one cycle.
- redirect_valid is sampled only at rising clock edges. No handshake back to the requester.

## Structure
- The shared package cpu_pkg holds:
  - the redirect_mode encodings (MODE_BRANCH, MODE_JUMP, MODE_JREG, MODE_RSVD),
  - the FSM state constants (ST_RUN, ST_HOLD),
  - the constant INSTR_INDEX_W = 26.
- One combinational sub-module, pc_target_calc, computes the target and the misaligned condition from mode, base, instr and rs_value. The top level holds the PC, the target register, the FSM and slot_done.

## Test plan
- Reset, then 3 unstalled cycles: pc = 0, 4, 8, 12. Assert rst_n low mid-run: pc = RESET_VEC immediately.
- DELAY_SLOT = 0, base 32'h0040_0010, BRANCH, instr[15:0] = 16'hFFFC: pc = 32'h0040_0004 one cycle later. Repeat with JUMP, base 32'h1000_0000, instr[25:0] = 26'h0000100: pc = 32'h1000_0400.
- DELAY_SLOT = 0, redirect with stall high for 2 cycles: pc held and redirect_pending = 1 for 2 cycles. Target appears on the edge after stall drops.
- DELAY_SLOT = 1, pc = 32'h100, JREG with rs_value = 32'h2003: pc = 32'h104, then 32'h2000. misaligned pulses for one cycle.
- DELAY_SLOT = 1, second redirect in the delay-slot cycle: redirect_drop = 1 for one cycle and the first target is taken.
- pc = 32'hFFFF_FFFC, no redirect: next pc = 32'h0000_0000. Reserved mode with redirect_valid: sequential pc, no flags.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the redirect_mode encodings, the next-PC FSM state type and the
// width of the jump instruction index field.
package cpu_pkg;

  localparam logic [1:0] MODE_BRANCH = 2'd0;
  localparam logic [1:0] MODE_JUMP   = 2'd1;
  localparam logic [1:0] MODE_JREG   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam int INSTR_INDEX_W = 26;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target calculator.
// Ports:
//   mode       redirect kind (BRANCH / JUMP / JREG / reserved)
//   base       PC of the control instruction
//   instr      low 26 bits of the control instruction word
//   rs_value   register operand for JREG
//   target     computed target address (modulo 2^ADDR_W)
//   legal      mode is not the reserved encoding
//   misaligned JREG operand had non-zero low bits
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        base,
  input  logic [INSTR_INDEX_W-1:0] instr,
  input  logic [ADDR_W-1:0]        rs_value,
  output logic [ADDR_W-1:0]        target,
  output logic                     legal,
  output logic                     misaligned
);

  logic [ADDR_W-1:0] b4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;

  assign b4     = base + ADDR_W'(4);
  // 16-bit word offset, sign-extended and scaled to bytes in one concatenation
  assign br_off = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign br_tgt = b4 + br_off;
  assign jr_tgt = {rs_value[ADDR_W-1:2], 2'b00};

  // At ADDR_W = 28 the index fills the whole address; no region bits remain
  generate
    if (ADDR_W > 28) begin : g_region
      assign j_tgt = {b4[ADDR_W-1:28], instr, 2'b00};
    end else begin : g_no_region
      assign j_tgt = {instr, 2'b00};
    end
  endgenerate

  always_comb begin
    target     = '0;
    legal      = 1'b1;
    misaligned = 1'b0;
    case (mode)
      MODE_BRANCH: target = br_tgt;
      MODE_JUMP:   target = j_tgt;
      MODE_JREG: begin
        target     = jr_tgt;
        misaligned = (rs_value[1:0] != 2'b00);
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter register and next fetch address generator.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | no target pending; pc advances sequentially or redirects
//   ST_HOLD | target_q valid; applied once unstalled (after the delay
//           | slot when DELAY_SLOT = 1)
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stall             hold pc this cycle
//   redirect_valid    control transfer requested (mode/base/instr/rs_value)
//   pc, pc_plus4      current fetch address and its sequential successor
//   redirect_pending  a captured target waits to be applied
//   misaligned        one-cycle pulse, accepted JREG with rs_value[1:0] != 0
//   redirect_drop     one-cycle pulse, redirect ignored while one pending
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter bit                DELAY_SLOT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_mode,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] rs_value,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_pending,
  output logic              misaligned,
  output logic              redirect_drop
);

  state_t            state;
  logic              slot_done;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] calc_target;
  logic              calc_legal;
  logic              calc_mis;
  logic              accept;
  logic              unused_instr_hi;

  assign unused_instr_hi = ^instr[31:INSTR_INDEX_W];

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_calc (
    .mode       (redirect_mode),
    .base       (redirect_base),
    .instr      (instr[INSTR_INDEX_W-1:0]),
    .rs_value   (rs_value),
    .target     (calc_target),
    .legal      (calc_legal),
    .misaligned (calc_mis)
  );

  // Reserved mode behaves as if no redirect was presented at all
  assign accept           = redirect_valid & calc_legal;
  assign pc_plus4         = pc + ADDR_W'(4);
  assign redirect_pending = (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pc            <= RESET_VEC;
      target_q      <= '0;
      slot_done     <= 1'b0;
      misaligned    <= 1'b0;
      redirect_drop <= 1'b0;
    end else begin
      misaligned    <= 1'b0;
      redirect_drop <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            misaligned <= calc_mis;
            if (!DELAY_SLOT && !stall) begin
              pc <= calc_target;
            end else begin
              target_q  <= calc_target;
              state     <= ST_HOLD;
              // An unstalled accept with a delay slot fetches the slot now
              slot_done <= DELAY_SLOT && !stall;
              if (!stall) pc <= pc_plus4;
            end
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        ST_HOLD: begin
          redirect_drop <= accept;
          if (!stall) begin
            if (!DELAY_SLOT || slot_done) begin
              pc        <= target_q;
              state     <= ST_RUN;
              slot_done <= 1'b0;
            end else begin
              pc        <= pc_plus4;
              slot_done <= 1'b1;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_mode = 2'd0;
  logic [31:0] redirect_base = '0;
  logic [31:0] instr = '0;
  logic [31:0] rs_value = '0;

  logic [31:0] pc0, pc_plus4_0, pc1, pc_plus4_1;
  logic        pend0, mis0, drop0, pend1, mis1, drop1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_mode(redirect_mode), .redirect_base(redirect_base), .instr(instr),
    .rs_value(rs_value), .pc(pc0), .pc_plus4(pc_plus4_0),
    .redirect_pending(pend0), .misaligned(mis0), .redirect_drop(drop0));

  next_pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_mode(redirect_mode), .redirect_base(redirect_base), .instr(instr),
    .rs_value(rs_value), .pc(pc1), .pc_plus4(pc_plus4_1),
    .redirect_pending(pend1), .misaligned(mis1), .redirect_drop(drop1));

  // Reference model: a pending target plus a count of sequential fetches
  // still owed before it takes effect.
  logic [31:0] m_pc[2];
  logic [31:0] m_tgt[2];
  bit          m_pend[2];
  bit          m_mis[2];
  bit          m_drop[2];
  int          m_slots[2];

  function automatic logic [31:0] ref_target(input logic [1:0] m, input logic [31:0] b,
                                             input logic [31:0] ins, input logic [31:0] rs);
    logic [31:0] b4;
    int          off;
    b4  = b + 32'd4;
    off = $signed(ins[15:0]);
    case (m)
      2'd0:    return b4 + 32'(off * 4);
      2'd1:    return (b4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      2'd2:    return rs & ~32'd3;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 32'h0; m_tgt[d] = 32'h0; m_pend[d] = 0;
      m_mis[d] = 0; m_drop[d] = 0; m_slots[d] = 0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] t;
    bit          acc;
    t   = ref_target(redirect_mode, redirect_base, instr, rs_value);
    acc = redirect_valid && (redirect_mode != 2'd3);
    for (int d = 0; d < 2; d++) begin
      m_mis[d]  = 0;
      m_drop[d] = 0;
      if (!m_pend[d]) begin
        if (acc) begin
          m_mis[d] = (redirect_mode == 2'd2) && (rs_value[1:0] != 2'b00);
          if (d == 0 && !stall) m_pc[d] = t;
          else begin
            m_pend[d] = 1; m_tgt[d] = t; m_slots[d] = d;
            if (!stall) begin m_pc[d] = m_pc[d] + 32'd4; m_slots[d] = 0; end
          end
        end else if (!stall) m_pc[d] = m_pc[d] + 32'd4;
      end else begin
        m_drop[d] = acc;
        if (!stall) begin
          if (m_slots[d] == 0) begin m_pc[d] = m_tgt[d]; m_pend[d] = 0; end
          else begin m_pc[d] = m_pc[d] + 32'd4; m_slots[d]--; end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m0_pc",   {32'h0, pc0},        {32'h0, m_pc[0]});
    chk("m0_pc4",  {32'h0, pc_plus4_0}, {32'h0, m_pc[0] + 32'd4});
    chk("m0_pend", {63'h0, pend0},      {63'h0, m_pend[0]});
    chk("m0_mis",  {63'h0, mis0},       {63'h0, m_mis[0]});
    chk("m0_drop", {63'h0, drop0},      {63'h0, m_drop[0]});
    chk("m1_pc",   {32'h0, pc1},        {32'h0, m_pc[1]});
    chk("m1_pc4",  {32'h0, pc_plus4_1}, {32'h0, m_pc[1] + 32'd4});
    chk("m1_pend", {63'h0, pend1},      {63'h0, m_pend[1]});
    chk("m1_mis",  {63'h0, mis1},       {63'h0, m_mis[1]});
    chk("m1_drop", {63'h0, drop1},      {63'h0, m_drop[1]});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    model_reset();
    #1;
    chk("rst_pc0",   {32'h0, pc0}, 64'h0);
    chk("rst_pc1",   {32'h0, pc1}, 64'h0);
    chk("rst_flags", {58'h0, pend0, mis0, drop0, pend1, mis1, drop1}, 64'h0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_redir(input logic [1:0] m, input logic [31:0] b,
                           input logic [31:0] ins, input logic [31:0] rs);
    redirect_valid = 1'b1;
    redirect_mode  = m;
    redirect_base  = b;
    instr          = ins;
    rs_value       = rs;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] base;
    logic [31:0] ins;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 32'h0040_0010, 32'h0000_FFFC, 32'h0,         32'h0040_0004, 1'b0};
    vecs[1] = '{2'd1, 32'h1000_0000, 32'h0000_0100, 32'h0,         32'h1000_0400, 1'b0};
    vecs[2] = '{2'd0, 32'h0000_0100, 32'h0000_0010, 32'h0,         32'h0000_0144, 1'b0};
    vecs[3] = '{2'd2, 32'h0,         32'h0,         32'h0000_2003, 32'h0000_2000, 1'b1};
    vecs[4] = '{2'd2, 32'h0,         32'h0,         32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{2'd1, 32'hF000_0000, 32'h03FF_FFFF, 32'h0,         32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{2'd0, 32'hFFFF_FFF8, 32'h0000_7FFF, 32'h0,         32'h0001_FFF8, 1'b0};
    vecs[7] = '{2'd3, 32'h1234_5678, 32'h0000_0100, 32'h0000_0003, 32'h0000_0004, 1'b0};
    vecs[8] = '{2'd1, 32'hEFFF_FFFC, 32'h0000_0001, 32'h0,         32'hF000_0004, 1'b0};

    // Reset and sequential run, then async reset mid-run
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("seq%0d_pc0", i), {32'h0, pc0}, 64'(i * 4));
      chk($sformatf("seq%0d_pc1", i), {32'h0, pc1}, 64'(i * 4));
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc0", {32'h0, pc0}, 64'h0);
    chk("async_rst_pc1", {32'h0, pc1}, 64'h0);
    rst_n = 1'b1;

    // Table: one unstalled redirect from pc = 0 on the no-delay-slot unit
    for (int i = 0; i < 9; i++) begin
      do_reset();
      set_redir(vecs[i].mode, vecs[i].base, vecs[i].ins, vecs[i].rs);
      step();
      redirect_valid = 1'b0;
      chk($sformatf("vec%0d_pc", i),   {32'h0, pc0},  {32'h0, vecs[i].exp_pc});
      chk($sformatf("vec%0d_mis", i),  {63'h0, mis0}, {63'h0, vecs[i].exp_mis});
      chk($sformatf("vec%0d_pend", i), {63'h0, pend0}, 64'h0);
      chk($sformatf("vec%0d_drop", i), {63'h0, drop0}, 64'h0);
    end

    // Redirect under a 2-cycle stall, no delay slot
    do_reset();
    set_redir(2'd1, 32'h1000_0000, 32'h0000_0100, 32'h0);
    stall = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("stall1_pc",   {32'h0, pc0},  64'h0);
    chk("stall1_pend", {63'h0, pend0}, 64'h1);
    step();
    chk("stall2_pc",   {32'h0, pc0},  64'h0);
    chk("stall2_pend", {63'h0, pend0}, 64'h1);
    stall = 1'b0;
    step();
    chk("stall_tgt_pc",   {32'h0, pc0},  64'h1000_0400);
    chk("stall_tgt_pend", {63'h0, pend0}, 64'h0);

    // Delay slot JREG from pc = 0x100
    do_reset();
    for (int i = 0; i < 64; i++) step();
    chk("ds_start_pc1", {32'h0, pc1}, 64'h100);
    set_redir(2'd2, 32'h100, 32'h0, 32'h0000_2003);
    step();
    redirect_valid = 1'b0;
    chk("ds_slot_pc1", {32'h0, pc1},  64'h104);
    chk("ds_slot_mis", {63'h0, mis1}, 64'h1);
    chk("ds_slot_pnd", {63'h0, pend1}, 64'h1);
    step();
    chk("ds_tgt_pc1", {32'h0, pc1},  64'h2000);
    chk("ds_tgt_mis", {63'h0, mis1}, 64'h0);

    // Second redirect in the delay-slot cycle is dropped
    set_redir(2'd1, 32'h1000_0000, 32'h0000_0100, 32'h0);
    step();
    chk("drop_slot_pc1", {32'h0, pc1}, 64'h2004);
    set_redir(2'd0, 32'h0, 32'h0000_0010, 32'h0);
    step();
    redirect_valid = 1'b0;
    chk("drop_pc1",   {32'h0, pc1},  64'h1000_0400);
    chk("drop_pulse", {63'h0, drop1}, 64'h1);
    step();
    chk("drop_end_pc1", {32'h0, pc1},  64'h1000_0404);
    chk("drop_end",     {63'h0, drop1}, 64'h0);

    // Top-word wrap and reserved mode
    do_reset();
    set_redir(2'd1, 32'hF000_0000, 32'h03FF_FFFF, 32'h0);
    step();
    redirect_valid = 1'b0;
    chk("wrap_top_pc0", {32'h0, pc0}, 64'hFFFF_FFFC);
    step();
    chk("wrap_pc0", {32'h0, pc0}, 64'h0);
    set_redir(2'd3, 32'h0, 32'h0, 32'h3);
    step();
    redirect_valid = 1'b0;
    chk("rsvd_pc0",   {32'h0, pc0}, 64'h4);
    chk("rsvd_flags", {61'h0, pend0, mis0, drop0}, 64'h0);

    // Async reset while holding a captured target
    do_reset();
    set_redir(2'd1, 32'h1000_0000, 32'h0000_0100, 32'h0);
    stall = 1'b1;
    step();
    redirect_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("hold_rst_pend", {62'h0, pend0, pend1}, 64'h0);
    chk("hold_rst_pc",   {pc1, pc0}, 64'h0);
    rst_n = 1'b1;
    stall = 1'b0;
    step();
    chk("hold_rst_seq", {pc1, pc0}, {32'h4, 32'h4});

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      redirect_valid = ($urandom_range(0, 2) == 0);
      redirect_mode  = 2'($urandom_range(0, 3));
      redirect_base  = $urandom;
      instr          = $urandom;
      rs_value       = $urandom;
      stall          = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
